// File: rtl/arp_cam_rnd_checker_pkg.sv
// Shared definitions for the ARP CAM random-replacement LFSR.
// The generator and the checker both import this package, so the
// polynomial, seed and next-state function are defined in one place.
package arp_cam_rnd_checker_pkg;

  localparam int RND_WIDTH = 16;
  localparam logic [RND_WIDTH-1:0] RND_POLY = 16'hD35B;
  localparam logic [RND_WIDTH-1:0] RND_SEED = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } rnd_state_e;

  // Galois right-shift step: shift right, then fold in the polynomial
  // whenever the bit shifted out was a one.
  function automatic logic [RND_WIDTH-1:0] rnd_nxt(input logic [RND_WIDTH-1:0] x);
    return {1'b0, x[RND_WIDTH-1:1]} ^ (x[0] ? RND_POLY : {RND_WIDTH{1'b0}});
  endfunction

endpackage

// File: rtl/arp_cam_rnd_step.sv
// One combinational step of the ARP CAM random-replacement LFSR.
module arp_cam_rnd_step
  import arp_cam_rnd_checker_pkg::*;
(
  input  logic [RND_WIDTH-1:0] i_cur,
  output logic [RND_WIDTH-1:0] o_nxt
);

  // Next value of the sequence, taken from the shared package function.
  always_comb begin
    o_nxt = rnd_nxt(i_cur);
  end

endmodule

// File: rtl/arp_cam_rnd_checker.sv
// Checker that locks onto the ARP CAM random-replacement LFSR stream and
// flags samples that break the sequence once locked.
// Optional error counter (ErrCnt/ErrClr) is built only when the macro
// ARP_CAM_RND_CHK_ERRCNT_EN is defined.
module arp_cam_rnd_checker
  import arp_cam_rnd_checker_pkg::*;
#(
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_THR = 4
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 InValid,
  input  logic [RND_WIDTH-1:0] InData,
  output logic                 Locked,
  output logic                 ErrPulse,
  output logic                 Lost
`ifdef ARP_CAM_RND_CHK_ERRCNT_EN
  ,
  input  logic                 ErrClr,
  output logic [RND_WIDTH-1:0] ErrCnt
`endif
);

  localparam int MatchW = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
  localparam int MissW  = (UNLOCK_THR < 1) ? 1 : $clog2(UNLOCK_THR + 1);
  localparam logic [MatchW-1:0] LockCntC   = MatchW'(LOCK_CNT);
  localparam logic [MissW-1:0]  UnlockThrC = MissW'(UNLOCK_THR);

  rnd_state_e           r_state;
  logic [RND_WIDTH-1:0] r_expected;
  logic [MatchW-1:0]    r_matchCnt;
  logic [MissW-1:0]     r_missCnt;
  logic                 r_locked;
  logic                 r_errPulse;
  logic                 r_lost;

  logic [RND_WIDTH-1:0] w_expNxt;
  logic [RND_WIDTH-1:0] w_seedNxt;
  logic                 w_match;
  logic                 w_errEvent;
  logic [MatchW-1:0]    w_matchInc;
  logic [MissW-1:0]     w_missInc;

  arp_cam_rnd_step u_step (
    .i_cur (r_expected),
    .o_nxt (w_expNxt)
  );

  assign w_seedNxt  = rnd_nxt(InData);
  assign w_match    = (InData == r_expected);
  assign w_errEvent = InValid && (r_state == ST_LOCKED) && !w_match;
  assign w_matchInc = r_matchCnt + 1'b1;
  assign w_missInc  = r_missCnt + 1'b1;

  // Hunt/verify/locked tracking; the strobes are rebuilt every cycle and
  // idle cycles (InValid low) leave state, counts and Expected untouched.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state    <= ST_HUNT;
      r_expected <= RND_SEED;
      r_matchCnt <= '0;
      r_missCnt  <= '0;
      r_locked   <= 1'b0;
      r_errPulse <= 1'b0;
      r_lost     <= 1'b0;
    end else begin
      r_errPulse <= w_errEvent;
      r_lost     <= 1'b0;
      if (InValid) begin
        case (r_state)
          ST_HUNT: begin
            if (InData != '0) begin
              r_expected <= w_seedNxt;
              r_matchCnt <= '0;
              r_state    <= ST_VERIFY;
            end
          end
          ST_VERIFY: begin
            if (w_match) begin
              r_expected <= w_expNxt;
              r_matchCnt <= w_matchInc;
              if (w_matchInc == LockCntC) begin
                r_state   <= ST_LOCKED;
                r_locked  <= 1'b1;
                r_missCnt <= '0;
              end
            end else if (InData != '0) begin
              r_expected <= w_seedNxt;
              r_matchCnt <= '0;
            end else begin
              r_state    <= ST_HUNT;
              r_matchCnt <= '0;
            end
          end
          ST_LOCKED: begin
            r_expected <= w_expNxt;
            if (w_match) begin
              r_missCnt <= '0;
            end else if (w_missInc == UnlockThrC) begin
              r_lost    <= 1'b1;
              r_locked  <= 1'b0;
              r_state   <= ST_HUNT;
              r_missCnt <= '0;
            end else begin
              r_missCnt <= w_missInc;
            end
          end
          default: begin
            r_state  <= ST_HUNT;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Locked   = r_locked;
  assign ErrPulse = r_errPulse;
  assign Lost     = r_lost;

`ifdef ARP_CAM_RND_CHK_ERRCNT_EN
  logic [RND_WIDTH-1:0] r_errCnt;

  // Saturating mismatch counter; a clear in the same cycle as an error wins.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_errCnt <= '0;
    end else if (ErrClr) begin
      r_errCnt <= '0;
    end else if (w_errEvent && (r_errCnt != {RND_WIDTH{1'b1}})) begin
      r_errCnt <= r_errCnt + 1'b1;
    end
  end

  assign ErrCnt = r_errCnt;
`endif

endmodule

// File: tb/tb_arp_cam_rnd_checker.sv
// Self-checking bench for arp_cam_rnd_checker: directed scenarios with
// literal expectations, then randomized streams checked every cycle
// against a sample-level behavioural model.
module tb_arp_cam_rnd_checker;

  localparam int LOCK_CNT   = 3;
  localparam int UNLOCK_THR = 4;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        InValid = 1'b0;
  logic [15:0] InData = 16'h0000;
  logic        Locked;
  logic        ErrPulse;
  logic        Lost;
`ifdef ARP_CAM_RND_CHK_ERRCNT_EN
  logic        ErrClr = 1'b0;
  logic [15:0] ErrCnt;
  logic        InValid2 = 1'b0;
  logic [15:0] InData2 = 16'h0000;
  logic        ErrClr2 = 1'b0;
  logic        Locked2;
  logic        ErrPulse2;
  logic        Lost2;
  logic [15:0] ErrCnt2;
`endif

  int nAssert = 0;
  int nFail   = 0;
  bit checkEn = 1'b0;

  arp_cam_rnd_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_THR(UNLOCK_THR)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .InValid  (InValid),
    .InData   (InData),
    .Locked   (Locked),
    .ErrPulse (ErrPulse),
    .Lost     (Lost)
`ifdef ARP_CAM_RND_CHK_ERRCNT_EN
    ,
    .ErrClr   (ErrClr),
    .ErrCnt   (ErrCnt)
`endif
  );

`ifdef ARP_CAM_RND_CHK_ERRCNT_EN
  // Second instance with a huge unlock threshold so the counter can be
  // driven to saturation without losing lock.
  arp_cam_rnd_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_THR(70000)) dutSat (
    .Clk      (Clk),
    .Rst      (Rst),
    .InValid  (InValid2),
    .InData   (InData2),
    .Locked   (Locked2),
    .ErrPulse (ErrPulse2),
    .Lost     (Lost2),
    .ErrClr   (ErrClr2),
    .ErrCnt   (ErrCnt2)
  );
`endif

  always #5 Clk = ~Clk;

  // Sequence step written as plain integer arithmetic.
  function automatic int mNxt(input int x);
    int r;
    r = x >> 1;
    if ((x & 1) != 0) r = r ^ 54107;
    return r;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one update per accepted sample.
  int mMode;     // 0 hunting, 1 verifying, 2 locked
  int mExp;
  int mCnt;
  int mMiss;
  int mErrCnt;
  bit mLocked, mErr, mLost;

  always @(posedge Clk or posedge Rst) begin
    int d;
    if (Rst) begin
      mMode = 0; mExp = 65535; mCnt = 0; mMiss = 0; mErrCnt = 0;
      mLocked = 0; mErr = 0; mLost = 0;
    end else begin
      mErr = 0;
      mLost = 0;
      if (InValid) begin
        d = int'(InData);
        if (mMode == 0) begin
          if (d != 0) begin mExp = mNxt(d); mCnt = 0; mMode = 1; end
        end else if (mMode == 1) begin
          if (d == mExp) begin
            mExp = mNxt(mExp);
            mCnt++;
            if (mCnt == LOCK_CNT) begin mMode = 2; mMiss = 0; end
          end else if (d != 0) begin
            mExp = mNxt(d); mCnt = 0;
          end else begin
            mMode = 0; mCnt = 0;
          end
        end else begin
          if (d != mExp) begin
            mErr = 1;
            mMiss++;
            if (mMiss == UNLOCK_THR) begin mLost = 1; mMode = 0; mMiss = 0; end
          end else begin
            mMiss = 0;
          end
          mExp = mNxt(mExp);
        end
      end
`ifdef ARP_CAM_RND_CHK_ERRCNT_EN
      if (ErrClr) mErrCnt = 0;
      else if (mErr && mErrCnt < 65535) mErrCnt++;
`endif
      mLocked = (mMode == 2);
    end
  end

  // Per-cycle comparison of the DUT against the model, away from the edge.
  always @(negedge Clk) begin
    if (checkEn) begin
      checkVal("model.Locked", 32'(Locked), 32'(mLocked));
      checkVal("model.ErrPulse", 32'(ErrPulse), 32'(mErr));
      checkVal("model.Lost", 32'(Lost), 32'(mLost));
`ifdef ARP_CAM_RND_CHK_ERRCNT_EN
      checkVal("model.ErrCnt", 32'(ErrCnt), 32'(mErrCnt));
`endif
    end
  end

  task automatic applyStimulus(input bit v, input logic [15:0] d);
    InValid = v;
    InData  = d;
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input bit l, input bit e, input bit lo);
    checkVal({tag, ".Locked"}, 32'(Locked), 32'(l));
    checkVal({tag, ".ErrPulse"}, 32'(ErrPulse), 32'(e));
    checkVal({tag, ".Lost"}, 32'(Lost), 32'(lo));
  endtask

  task automatic checkErrCnt(input string tag, input int exp);
`ifdef ARP_CAM_RND_CHK_ERRCNT_EN
    checkVal({tag, ".ErrCnt"}, 32'(ErrCnt), 32'(exp));
`else
    if (exp < 0) $display("[TB] note %s", tag);
`endif
  endtask

  task automatic lockSequence(input string tag);
    applyStimulus(1'b1, 16'hFFFF); checkOutput({tag, ".s0"}, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hACA4); checkOutput({tag, ".s1"}, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h5652); checkOutput({tag, ".s2"}, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h2B29); checkOutput({tag, ".s3"}, 1'b1, 1'b0, 1'b0);
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int e;
    int gv;
    int garbage;
    int r;
    logic [15:0] d;
    bit v;

    // Reset and reset values.
    #2 Rst = 1'b1;
    #1 checkEn = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    checkOutput("reset", 1'b0, 1'b0, 1'b0);
    checkErrCnt("reset", 0);
    Rst = 1'b0;
    applyStimulus(1'b0, 16'h0000);

    // Basic lock from the reset seed.
    lockSequence("lock");

    // Single bad sample while locked, then the flywheel continuation.
    applyStimulus(1'b1, 16'hC6CF); checkOutput("single.ok", 1'b1, 1'b0, 1'b0);
    e = mNxt(16'hC6CF);
    applyStimulus(1'b1, 16'h1234); checkOutput("single.bad", 1'b1, 1'b1, 1'b0);
    checkErrCnt("single.bad", 1);
    e = mNxt(e);
    applyStimulus(1'b1, 16'(e)); checkOutput("single.cont", 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000); checkOutput("single.idle", 1'b1, 1'b0, 1'b0);

    // Four consecutive wrong samples drop the lock.
    e = mNxt(e);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 16'(e ^ 16'h0101));
      e = mNxt(e);
      if (i < 3) checkOutput("unlock.miss", 1'b1, 1'b1, 1'b0);
      else       checkOutput("unlock.lost", 1'b0, 1'b1, 1'b1);
    end
    checkErrCnt("unlock", 5);
    applyStimulus(1'b0, 16'h0000); checkOutput("unlock.after", 1'b0, 1'b0, 1'b0);

    // Zero is ignored while hunting.
    applyStimulus(1'b1, 16'h0000); checkOutput("zero", 1'b0, 1'b0, 1'b0);
    lockSequence("relock");
    applyStimulus(1'b1, 16'hC6CF); checkOutput("relock.ok", 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-stream, then relock needs LOCK_CNT+1 samples.
    #2 Rst = 1'b1;
    #1;
    checkVal("async.Locked", 32'(Locked), 32'd0);
    checkErrCnt("async", 0);
    @(posedge Clk);
    #1 Rst = 1'b0;
    applyStimulus(1'b1, 16'h5652); checkOutput("arst.s0", 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h2B29); checkOutput("arst.s1", 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hC6CF); checkOutput("arst.s2", 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hB03C); checkOutput("arst.s3", 1'b1, 1'b0, 1'b0);

    // Randomized streams: mostly correct continuation with noise, zeros,
    // skips, reseeds, gaps and periodic garbage bursts.
    gv = mNxt(16'hB03C);
    garbage = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ((cyc % 250) == 100) garbage = 6;
      v = ($urandom % 4) != 0;
      d = 16'($urandom);
      if (v) begin
        if (garbage > 0) begin
          garbage--;
        end else begin
          r = int'($urandom % 100);
          if (r < 82) begin
            d = 16'(gv); gv = mNxt(gv);
          end else if (r < 90) begin
            d = 16'($urandom);
          end else if (r < 93) begin
            d = 16'h0000;
          end else if (r < 96) begin
            gv = mNxt(gv); d = 16'(gv); gv = mNxt(gv);
          end else begin
            gv = int'($urandom_range(1, 65535)); d = 16'(gv); gv = mNxt(gv);
          end
        end
      end
`ifdef ARP_CAM_RND_CHK_ERRCNT_EN
      ErrClr = ($urandom % 25) == 0;
`endif
      applyStimulus(v, d);
      if (cyc == 1500) begin
        #2 Rst = 1'b1;
        @(posedge Clk);
        #1 Rst = 1'b0;
      end
    end
`ifdef ARP_CAM_RND_CHK_ERRCNT_EN
    ErrClr = 1'b0;
`endif
    applyStimulus(1'b0, 16'h0000);

`ifdef ARP_CAM_RND_CHK_ERRCNT_EN
    // Saturation of the error counter on the high-threshold instance.
    InValid2 = 1'b1;
    InData2 = 16'hFFFF; @(posedge Clk); #1;
    InData2 = 16'hACA4; @(posedge Clk); #1;
    InData2 = 16'h5652; @(posedge Clk); #1;
    InData2 = 16'h2B29; @(posedge Clk); #1;
    checkVal("sat.lock", 32'(Locked2), 32'd1);
    e = 16'hC6CF;
    for (int i = 0; i < 65535; i++) begin
      InData2 = 16'(e ^ 1);
      e = mNxt(e);
      @(posedge Clk);
      #1;
    end
    checkVal("sat.full", 32'(ErrCnt2), 32'hFFFF);
    checkVal("sat.locked", 32'(Locked2), 32'd1);
    InData2 = 16'(e ^ 1); e = mNxt(e);
    @(posedge Clk); #1;
    checkVal("sat.hold", 32'(ErrCnt2), 32'hFFFF);
    checkVal("sat.pulse", 32'(ErrPulse2), 32'd1);
    ErrClr2 = 1'b1;
    InData2 = 16'(e ^ 1);
    @(posedge Clk); #1;
    checkVal("sat.clrwins", 32'(ErrCnt2), 32'd0);
    ErrClr2 = 1'b0;
    InValid2 = 1'b0;
`endif

    repeat (2) @(posedge Clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
